// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle for the iterative multiply/divide unit
//
// Ports (master = issuing side, slave = muldiv_unit):
//   start, funct3, rs1_data, rs2_data, rd_in, kill : master -> slave
//   busy, done, reg_write, result, rd_out          : slave -> master
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            kill;
    logic            busy;
    logic            done;
    logic            reg_write;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in, kill,
        input  busy, done, reg_write, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in, kill,
        output busy, done, reg_write, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears all state
//   bus    : muldiv_unit_if.slave
//            start/funct3/rs1_data/rs2_data/rd_in accepted when idle,
//            kill aborts an in-flight op, busy/done/reg_write/result/rd_out report it
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state;
    logic [2:0]        op;
    logic [4:0]        rd_lat;
    logic [5:0]        count;
    // Multiply: acc = partial product, mcand = shifted multiplicand, opb = multiplier.
    // Divide:   acc = {remainder, dividend/quotient}, opb = divisor magnitude.
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   opb;
    logic              neg_main;   // negate product / quotient
    logic              neg_rem;    // negate remainder (dividend sign)
    logic              special;    // acc[XLEN-1:0] already holds the final value
    logic              fin_hold;   // special results spend one extra cycle in FIN

    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN:0]     div_cand;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_val;

    // Operand decode on the incoming request.
    always_comb begin
        is_div   = bus.funct3[2];
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        a_neg    = a_signed && bus.rs1_data[XLEN-1];
        b_neg    = b_signed && bus.rs2_data[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
        div_zero = is_div && (bus.rs2_data == '0);
        div_ovf  = is_div && !bus.funct3[0] &&
                   (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (bus.rs2_data == {XLEN{1'b1}});
        spec_val = '0;
        if (div_zero)
            spec_val = bus.funct3[1] ? bus.rs1_data : {XLEN{1'b1}};
        else if (div_ovf)
            spec_val = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One restoring-division step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        div_cand = acc[2*XLEN-1:XLEN-1];
        div_diff = div_cand - {1'b0, opb};
    end

    // Sign fixup and result selection applied on the FIN edge.
    always_comb begin
        prod_fix = neg_main ? -acc : acc;
        quo_fix  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fin_val  = '0;
        if (special)
            fin_val = acc[XLEN-1:0];
        else if (!op[2])
            fin_val = (op == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            fin_val = op[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op            <= '0;
            rd_lat        <= '0;
            count         <= '0;
            acc           <= '0;
            mcand         <= '0;
            opb           <= '0;
            neg_main      <= 1'b0;
            neg_rem       <= 1'b0;
            special       <= 1'b0;
            fin_hold      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.reg_write <= 1'b0;
            bus.result    <= '0;
            bus.rd_out    <= '0;
        end else begin
            bus.done      <= 1'b0;
            bus.reg_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op       <= bus.funct3;
                        rd_lat   <= bus.rd_in;
                        count    <= '0;
                        opb      <= b_mag;
                        mcand    <= {{XLEN{1'b0}}, a_mag};
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        bus.busy <= 1'b1;
                        if (div_zero || div_ovf) begin
                            acc      <= {{XLEN{1'b0}}, spec_val};
                            special  <= 1'b1;
                            fin_hold <= 1'b1;
                            state    <= FIN;
                        end else begin
                            // Divide starts with the dividend in the low half.
                            acc      <= is_div ? {{XLEN{1'b0}}, a_mag} : '0;
                            special  <= 1'b0;
                            fin_hold <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.kill) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        if (!op[2]) begin
                            if (opb[0])
                                acc <= acc + mcand;
                            mcand <= mcand << 1;
                            opb   <= opb >> 1;
                        end else if (!div_diff[XLEN]) begin
                            acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        end else begin
                            acc <= {div_cand[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                        end
                        count <= count + 6'd1;
                        if (count == 6'(ITER - 1))
                            state <= FIN;
                    end
                end
                FIN: begin
                    if (bus.kill) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (fin_hold) begin
                        fin_hold <= 1'b0;
                    end else begin
                        bus.result    <= fin_val;
                        bus.rd_out    <= rd_lat;
                        bus.done      <= 1'b1;
                        bus.reg_write <= (rd_lat != 5'd0);
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.XLEN(32)) mif ();

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    // Results of the most recent do_op call.
    logic [31:0] o_res;
    int          o_lat;
    logic        o_rw;
    logic [4:0]  o_rdo;
    logic        o_bz;
    logic        o_done;
    logic        o_bk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op from the current (off-edge) time and track it until done or lim edges.
    // poke_at: edge count at which a stray start is pulsed; kill_at: edge count to pulse kill.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int poke_at, input int kill_at,
                         input int lim);
        mif.start    = 1'b1;
        mif.funct3   = f3;
        mif.rs1_data = a;
        mif.rs2_data = b;
        mif.rd_in    = rd;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        o_bz  = mif.busy;
        o_bk  = 1'b1;
        o_lat = 0;
        while (!mif.done && o_lat < lim) begin
            if (o_lat == poke_at) begin
                mif.start    = 1'b1;
                mif.funct3   = 3'b000;
                mif.rs1_data = 32'h1234_5678;
                mif.rs2_data = 32'h0000_0010;
                mif.rd_in    = 5'd9;
            end
            if (o_lat == kill_at)
                mif.kill = 1'b1;
            @(posedge clk);
            #1;
            mif.start = 1'b0;
            mif.kill  = 1'b0;
            o_lat++;
            if (o_lat == kill_at + 1)
                o_bk = mif.busy;
        end
        o_done = mif.done;
        o_res  = mif.result;
        o_rw   = mif.reg_write;
        o_rdo  = mif.rd_out;
    endtask

    initial begin
        logic [31:0] prev;
        int          spurious;

        mif.start    = 1'b0;
        mif.funct3   = 3'b000;
        mif.rs1_data = '0;
        mif.rs2_data = '0;
        mif.rd_in    = '0;
        mif.kill     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", mif.busy, 0);
        chk("rst_done", mif.done, 0);
        chk("rst_result", mif.result, 0);
        chk("rst_rd_out", mif.rd_out, 0);
        chk("rst_reg_write", mif.reg_write, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op(3'b000, 32'hFFFF_FFFE, 32'd3, 5'd5, -1, -1, 100);
        chk("mul_res", o_res, 32'hFFFF_FFFA);
        chk("mul_lat", o_lat, 33);
        chk("mul_rd", o_rdo, 5);
        chk("mul_rw", o_rw, 1);
        chk("mul_busy", o_bz, 1);
        @(negedge clk);
        do_op(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd6, -1, -1, 100);
        chk("mulh_res", o_res, 32'hFFFF_FFFF);
        chk("mulh_lat", o_lat, 33);
        @(negedge clk);
        do_op(3'b011, 32'hFFFF_FFFE, 32'd3, 5'd7, -1, -1, 100);
        chk("mulhu_res", o_res, 32'h0000_0002);
        chk("mulhu_lat", o_lat, 33);
        chk("mulhu_rd", o_rdo, 7);

        @(negedge clk);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1, -1, -1, 100);
        chk("div_res", o_res, 32'hFFFF_FFFD);
        @(negedge clk);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1, -1, -1, 100);
        chk("rem_res", o_res, 32'hFFFF_FFFF);
        @(negedge clk);
        do_op(3'b101, 32'd100, 32'd7, 5'd2, -1, -1, 100);
        chk("divu_res", o_res, 32'd14);
        chk("divu_lat", o_lat, 33);
        @(negedge clk);
        do_op(3'b111, 32'd100, 32'd7, 5'd2, -1, -1, 100);
        chk("remu_res", o_res, 32'd2);

        @(negedge clk);
        do_op(3'b100, 32'd5, 32'd0, 5'd3, -1, -1, 100);
        chk("div0_res", o_res, 32'hFFFF_FFFF);
        chk("div0_lat", o_lat, 2);
        @(negedge clk);
        do_op(3'b111, 32'd5, 32'd0, 5'd3, -1, -1, 100);
        chk("remu0_res", o_res, 32'd5);
        chk("remu0_lat", o_lat, 2);
        @(negedge clk);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, -1, -1, 100);
        chk("divovf_res", o_res, 32'h8000_0000);
        chk("divovf_lat", o_lat, 2);
        @(negedge clk);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, -1, -1, 100);
        chk("removf_res", o_res, 32'd0);

        // Stray start mid-CALC must not disturb the running DIVU.
        @(negedge clk);
        do_op(3'b101, 32'd100, 32'd7, 5'd8, 10, -1, 100);
        chk("poke_res", o_res, 32'd14);
        chk("poke_lat", o_lat, 33);
        chk("poke_rd", o_rdo, 8);

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        do_op(3'b000, 32'd6, 32'd7, 5'd10, -1, -1, 100);
        chk("b2b_first", o_res, 32'd42);
        do_op(3'b101, 32'd1000, 32'd10, 5'd11, -1, -1, 100);
        chk("b2b_busy", o_bz, 1);
        chk("b2b_second", o_res, 32'd100);
        chk("b2b_lat", o_lat, 33);
        chk("b2b_rd", o_rdo, 11);

        // x0 destination: done with no register write.
        @(negedge clk);
        do_op(3'b000, 32'd3, 32'd3, 5'd0, -1, -1, 100);
        chk("x0_done", o_done, 1);
        chk("x0_rw", o_rw, 0);
        chk("x0_res", o_res, 32'd9);

        // Kill at iteration 10 of a DIVU.
        @(negedge clk);
        prev = mif.result;
        do_op(3'b101, 32'd1000, 32'd3, 5'd12, -1, 10, 50);
        chk("kill_done", o_done, 0);
        chk("kill_busy", o_bk, 0);
        chk("kill_res", o_res, prev);
        @(negedge clk);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, -1, -1, 100);
        chk("mulhsu_res", o_res, 32'hFFFF_FFFF);
        chk("mulhsu_lat", o_lat, 33);

        // Asynchronous reset between edges mid-CALC.
        @(negedge clk);
        mif.start    = 1'b1;
        mif.funct3   = 3'b101;
        mif.rs1_data = 32'd500;
        mif.rs2_data = 32'd7;
        mif.rd_in    = 5'd14;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", mif.busy, 0);
        chk("arst_done", mif.done, 0);
        chk("arst_result", mif.result, 0);
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mif.done)
                spurious++;
        end
        chk("arst_no_done", spurious, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
